// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshakes and SRAM macro pins shared by the arbiter and its environment
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [31:0]       m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;
  logic                m1_req;
  logic [31:0]         m1_addr;
  logic [DATA_W/8-1:0] m1_we;
  logic [DATA_W-1:0]   m1_wdata;
  logic                m1_lock;
  logic                m1_gnt;
  logic                m1_rvalid;
  logic [DATA_W-1:0]   m1_rdata;
  logic                m1_err;
  logic                sram_cs;
  logic                sram_oe;
  logic [DATA_W/8-1:0] sram_web;
  logic [ADDR_W-1:0]   sram_a;
  logic [DATA_W-1:0]   sram_di;
  logic [DATA_W-1:0]   sram_do;
  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, m1_we, m1_wdata, m1_lock, sram_do,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output sram_cs, sram_oe, sram_web, sram_a, sram_di
  );
  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, m1_we, m1_wdata, m1_lock, sram_do,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  sram_cs, sram_oe, sram_web, sram_a, sram_di
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin fetch/load-store arbiter for one zero-latency SRAM with bounded m1 lock.
// Optional SRAM_ARB_PERF_EN adds saturating conflict/stall/forced-release counters.
module sram_port_arbiter #(
  parameter int          ADDR_W    = 14,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_LOCK  = 4
) (
  input logic clk,
  input logic rst_n,
  sram_port_arbiter_if.slave bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_m0_stall,
  output logic [15:0] perf_lock_force
`endif
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  typedef enum logic {ARB, LOCK} state_t;
  state_t      state;
  logic        rr_last;
  logic [LW-1:0] lock_cnt, nxt_cnt;
  logic [31:0] off0, off1;
  logic        in0, in1, g0, g1, act, rd, force_rel;
  always_comb begin
    off0      = bus.m0_addr - BASE_ADDR;
    off1      = bus.m1_addr - BASE_ADDR;
    in0       = off0[31:ADDR_W+2] == '0;
    in1       = off1[31:ADDR_W+2] == '0;
    g0        = rst_n && state == ARB && bus.m0_req && (!bus.m1_req || rr_last);
    g1        = rst_n && bus.m1_req && (state == LOCK || !bus.m0_req || !rr_last);
    act       = (g0 && in0) || (g1 && in1);
    rd        = g0 || bus.m1_we == '0;
    nxt_cnt   = state == LOCK ? lock_cnt + 1'b1 : LW'(1);
    force_rel = g1 && bus.m1_lock && nxt_cnt == LW'(MAX_LOCK);
  end
  assign bus.m0_gnt   = g0;
  assign bus.m1_gnt   = g1;
  assign bus.sram_cs  = act;
  assign bus.sram_oe  = act && rd;
  assign bus.sram_web = act && g1 ? ~bus.m1_we : '1;
  assign bus.sram_a   = act ? (g0 ? off0[ADDR_W+1:2] : off1[ADDR_W+1:2]) : '0;
  assign bus.sram_di  = act ? bus.m1_wdata : '0;
  // rr_last = 1 means m1 was granted last; a forced release is always an m1 grant so m0 wins next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB;
      rr_last       <= 1'b1;
      lock_cnt      <= '0;
      bus.m0_rvalid <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m1_rdata  <= '0;
    end else begin
      if (g0 || g1) rr_last <= g1;
      if (g1 && bus.m1_lock && !force_rel) begin
        state    <= LOCK;
        lock_cnt <= nxt_cnt;
      end else begin
        state    <= ARB;
        lock_cnt <= '0;
      end
      bus.m0_rvalid <= g0;
      bus.m0_err    <= g0 && !in0;
      bus.m0_rdata  <= g0 && in0 ? bus.sram_do : '0;
      bus.m1_rvalid <= g1;
      bus.m1_err    <= g1 && !in1;
      bus.m1_rdata  <= g1 && in1 && bus.m1_we == '0 ? bus.sram_do : '0;
    end
  end
`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict   <= '0;
      perf_m0_stall   <= '0;
      perf_lock_force <= '0;
    end else begin
      if (bus.m0_req && bus.m1_req && ~&perf_conflict) perf_conflict <= perf_conflict + 1'b1;
      if (bus.m0_req && !g0 && ~&perf_m0_stall) perf_m0_stall <= perf_m0_stall + 1'b1;
      if (force_rel && ~&perf_lock_force) perf_lock_force <= perf_lock_force + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scoreboard bench with a behavioural SRAM and an independent reference memory
module tb_sram_port_arbiter;
  localparam int AW = 14;
  localparam logic [31:0] BASE = 32'h0;
  typedef struct packed {logic err; logic [31:0] rdata;} resp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  resp_t q0[$];
  resp_t q1[$];
  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(32)) bus();
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_m0_stall;
  logic [15:0] perf_lock_force;
`endif
  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(32), .BASE_ADDR(BASE), .MAX_LOCK(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_m0_stall(perf_m0_stall),
    .perf_lock_force(perf_lock_force)
`endif
  );
  always #5 clk = ~clk;
  assign bus.sram_do = mem[bus.sram_a];
  always @(posedge clk)
    if (bus.sram_cs)
      for (int b = 0; b < 4; b++)
        if (!bus.sram_web[b]) mem[bus.sram_a][b*8+:8] <= bus.sram_di[b*8+:8];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd, output resp_t r);
    logic [31:0] off;
    int w;
    off = addr - BASE;
    r.err = 1'b0;
    r.rdata = '0;
    if ((off >> 2) >= (32'd1 << AW)) r.err = 1'b1;
    else begin
      w = int'(off >> 2);
      if (we == 4'b0) r.rdata = ref_mem[w];
      else for (int b = 0; b < 4; b++) if (we[b]) ref_mem[w][b*8+:8] = wd[b*8+:8];
    end
  endtask
  task automatic sample(input logic e0, input logic e1);
    resp_t r;
    @(negedge clk);
    if (q0.size() > 0) begin
      r = q0.pop_front();
      chk("m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
      chk("m0_err", 32'(bus.m0_err), 32'(r.err));
      chk("m0_rdata", bus.m0_rdata, r.rdata);
    end else begin
      chk("m0_rvalid_idle", 32'(bus.m0_rvalid), 32'd0);
      chk("m0_rdata_idle", bus.m0_rdata, 32'd0);
    end
    if (q1.size() > 0) begin
      r = q1.pop_front();
      chk("m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
      chk("m1_err", 32'(bus.m1_err), 32'(r.err));
      chk("m1_rdata", bus.m1_rdata, r.rdata);
    end else begin
      chk("m1_rvalid_idle", 32'(bus.m1_rvalid), 32'd0);
      chk("m1_rdata_idle", bus.m1_rdata, 32'd0);
    end
    chk("m0_gnt", 32'(bus.m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(bus.m1_gnt), 32'(e1));
    if (e0) begin model_access(bus.m0_addr, 4'b0, 32'b0, r); q0.push_back(r); end
    if (e1) begin model_access(bus.m1_addr, bus.m1_we, bus.m1_wdata, r); q1.push_back(r); end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic [3:0] we, input logic [31:0] wd, input logic lk);
    bus.m0_req = r0; bus.m0_addr = a0;
    bus.m1_req = r1; bus.m1_addr = a1; bus.m1_we = we; bus.m1_wdata = wd; bus.m1_lock = lk;
  endtask
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    // reset state with a pending request: no grant, no response
    set_req(1, 32'h10, 1, 32'h20, 4'b0, 32'b0, 0);
    sample(0, 0);
    chk("rst_cs", 32'(bus.sram_cs), 32'd0);
    chk("rst_web", 32'(bus.sram_web), 32'hF);
    tick();
    rst_n = 1'b1;
    // fetch from word 4
    set_req(1, 32'h10, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(1, 0);
    chk("fetch_a", 32'(bus.sram_a), 32'd4);
    chk("fetch_oe", 32'(bus.sram_oe), 32'd1);
    chk("fetch_cs", 32'(bus.sram_cs), 32'd1);
    tick();
    // byte-masked store then load back
    set_req(0, 32'h0, 1, 32'h20, 4'b0011, 32'hAABB_CCDD, 0);
    sample(0, 1);
    chk("fetch_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    chk("wr_web", 32'(bus.sram_web), 32'hC);
    chk("wr_oe", 32'(bus.sram_oe), 32'd0);
    chk("wr_a", 32'(bus.sram_a), 32'd8);
    chk("wr_di", bus.sram_di, 32'hAABB_CCDD);
    tick();
    set_req(0, 32'h0, 1, 32'h20, 4'b0, 32'b0, 0);
    sample(0, 1);
    chk("rd_web", 32'(bus.sram_web), 32'hF);
    tick();
    set_req(0, 32'h0, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(0, 0);
    chk("rmw_rdata", bus.m1_rdata, 32'h1122_CCDD);
    tick();
    // fresh reset, then sustained conflict alternates starting with m0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_req(1, 32'h10, 1, 32'h24, 4'b0, 32'b0, 0);
    sample(1, 0); tick();
    sample(0, 1); tick();
    sample(1, 0); tick();
    sample(0, 1); tick();
    set_req(0, 32'h0, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(0, 0); tick();
    // lock: m1 holds 4 grants, forced release gives m0 one, then m1 resumes
    set_req(1, 32'h14, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(1, 0); tick();
    set_req(1, 32'h14, 1, 32'h30, 4'b0, 32'b0, 1);
    for (int k = 0; k < 4; k++) begin sample(0, 1); tick(); end
    sample(1, 0); tick();
    sample(0, 1); tick();
    set_req(0, 32'h0, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(0, 0); tick();
`ifdef SRAM_ARB_PERF_EN
    chk("perf_lock_force", 32'(perf_lock_force), 32'd1);
    chk("perf_conflict", perf_conflict, 32'd10);
    chk("perf_m0_stall", perf_m0_stall, 32'd7);
`endif
    // window boundaries
    set_req(0, 32'h0, 1, 32'h0001_0000, 4'b0, 32'b0, 0);
    sample(0, 1);
    chk("oor_cs", 32'(bus.sram_cs), 32'd0);
    chk("oor_a", 32'(bus.sram_a), 32'd0);
    tick();
    set_req(1, 32'hFFFF_FFFC, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(1, 0);
    chk("oor_m1_err", 32'(bus.m1_err), 32'd1);
    tick();
    set_req(1, 32'h0000_FFFC, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(1, 0);
    chk("top_a", 32'(bus.sram_a), 32'h3FFF);
    chk("top_cs", 32'(bus.sram_cs), 32'd1);
    tick();
    set_req(0, 32'h0, 1, 32'h0000_FFFF, 4'b1111, 32'h0BAD_F00D, 0);
    sample(0, 1);
    chk("top_wr_a", 32'(bus.sram_a), 32'h3FFF);
    tick();
    set_req(0, 32'h0, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(0, 0); tick();
    // reset mid-lock drops the pending response and returns to ARB
    set_req(0, 32'h0, 1, 32'h40, 4'b0, 32'b0, 1);
    sample(0, 1); tick();
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    set_req(1, 32'h10, 1, 32'h40, 4'b0, 32'b0, 1);
    sample(0, 0); tick();
    rst_n = 1'b1;
    bus.m1_lock = 1'b0;
    sample(1, 0); tick();
    set_req(0, 32'h0, 0, 32'h0, 4'b0, 32'b0, 0);
    sample(0, 0); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
